// File: rtl/latch_bank_ctrl.sv
// Multi-entry capture bank for a switch bus: debounced capture button, scan display
// of the stored slots, and a live/stored mux onto the LEDs.
module latch_bank_ctrl #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int DEB_CYCLES   = 4,
  parameter int DWELL_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         D,
  input  logic                     cap_btn,
  input  logic                     scan_en,
  input  logic                     sel,
  output logic [WIDTH-1:0]         led,
  output logic [$clog2(DEPTH)-1:0] slot,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DBW = $clog2(DEB_CYCLES);
  localparam int DWW = $clog2(DWELL_CYCLES + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] SCAN    = 2'd2;

  logic [WIDTH-1:0] bank [DEPTH];
  logic             btn_p0, btn_s, deb, deb_d;
  logic [DBW-1:0]   deb_cnt;
  logic [1:0]       state, state_n;
  logic [AW-1:0]    wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n, slot_n;
  logic [CW-1:0]    count_n;
  logic [DWW-1:0]   dwell, dwell_n;
  logic             press, cap_go, do_write;

  // The scan walks only the filled slots, wrapping after the newest one.
  function automatic logic [AW-1:0] rd_advance(input logic [AW-1:0] p,
                                               input logic [CW-1:0] n);
    if ({1'b0, p} == n - CW'(1)) return '0;
    return p + AW'(1);
  endfunction

  assign press  = deb & ~deb_d;
  assign full   = (count == CW'(DEPTH));
  assign cap_go = press & ~full;
  assign led    = sel ? D : bank[slot];

  // Stage p0/p1: synchronizer, then debounce on btn_s
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_p0  <= 1'b0;
      btn_s   <= 1'b0;
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      btn_p0 <= cap_btn;
      btn_s  <= btn_p0;
      deb_d  <= deb;
      if (btn_s == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DBW'(DEB_CYCLES - 1)) begin
        deb     <= ~deb;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DBW'(1);
      end
    end
  end

  always_comb begin
    state_n  = state;
    wr_ptr_n = wr_ptr;
    count_n  = count;
    rd_ptr_n = rd_ptr;
    dwell_n  = dwell;
    do_write = 1'b0;
    case (state)
      IDLE: begin
        if (cap_go)                       state_n = CAPTURE;
        else if (scan_en && count != '0)  state_n = SCAN;
      end
      CAPTURE: begin
        do_write = 1'b1;
        wr_ptr_n = wr_ptr + AW'(1);
        count_n  = count + CW'(1);
        if (scan_en) begin
          state_n = SCAN;
        end else begin
          state_n  = IDLE;
          rd_ptr_n = '0;
          dwell_n  = '0;
        end
      end
      SCAN: begin
        if (cap_go) begin
          state_n = CAPTURE;
        end else if (!scan_en) begin
          state_n  = IDLE;
          rd_ptr_n = '0;
          dwell_n  = '0;
        end else if (dwell == DWW'(DWELL_CYCLES - 1)) begin
          dwell_n  = '0;
          rd_ptr_n = rd_advance(rd_ptr, count);
        end else begin
          dwell_n = dwell + DWW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == SCAN)      slot_n = rd_ptr_n;
    else if (count_n == '0)   slot_n = '0;
    else                      slot_n = wr_ptr_n - AW'(1);
  end

  // Stage p2: control state, pointers and the registered view slot
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dwell    <= '0;
      slot     <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      dwell    <= dwell_n;
      slot     <= slot_n;
      overflow <= press & full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else if (do_write) begin
      bank[wr_ptr] <= D;
    end
  end

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Bench for latch_bank_ctrl: scenario tasks with randomized data checked against a
// slot-list model of the bank (stored values, fill count, dwell-based scan sequence).
module tb_latch_bank_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int DEB   = 4;
  localparam int DWELL = 8;

  logic             clk = 1'b0;
  logic             rst, cap_btn, scan_en, sel;
  logic [WIDTH-1:0] D, led;
  logic [1:0]       slot;
  logic [2:0]       count;
  logic             full, overflow;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] bank_m [DEPTH];
  int               count_m;

  latch_bank_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEB_CYCLES(DEB), .DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .rst(rst), .D(D), .cap_btn(cap_btn), .scan_en(scan_en), .sel(sel),
    .led(led), .slot(slot), .count(count), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cap_btn = 1'b0; scan_en = 1'b0; sel = 1'b0; D = 8'hFF;
    tick(); tick();
    rst = 1'b0;
    count_m = 0;
    for (int i = 0; i < DEPTH; i++) bank_m[i] = '0;
  endtask

  // One clean press/release; model decides whether it stores or overflows.
  task automatic do_press(input logic [WIDTH-1:0] val);
    int ovf_pulses = 0;
    int ovf_run    = 0;
    int ovf_max    = 0;
    bit exp_ovf;
    D = val;
    cap_btn = 1'b1;
    for (int i = 0; i < DEB + 8; i++) begin
      tick();
      if (overflow) begin ovf_pulses++; ovf_run++; end else ovf_run = 0;
      if (ovf_run > ovf_max) ovf_max = ovf_run;
    end
    cap_btn = 1'b0;
    for (int i = 0; i < DEB + 6; i++) begin
      tick();
      if (overflow) begin ovf_pulses++; ovf_run++; end else ovf_run = 0;
      if (ovf_run > ovf_max) ovf_max = ovf_run;
    end
    exp_ovf = (count_m == DEPTH);
    if (!exp_ovf) begin
      bank_m[count_m] = val;
      count_m++;
    end
    checks++;
    if (ovf_pulses !== (exp_ovf ? 1 : 0) || ovf_max > 1) begin
      failures++;
      $display("FAIL press_overflow: pulses=%0d longest=%0d required pulses=%0d", ovf_pulses, ovf_max, exp_ovf ? 1 : 0);
    end
    checks++;
    if (count !== 3'(count_m) || full !== (count_m == DEPTH)) begin
      failures++;
      $display("FAIL press_count: count=%0d full=%0b required count=%0d full=%0b", count, full, count_m, count_m == DEPTH);
    end
    if (!scan_en && !sel) begin
      checks++;
      if (led !== bank_m[count_m-1]) begin
        failures++;
        $display("FAIL press_led: led=%h required %h", led, bank_m[count_m-1]);
      end
    end
  endtask

  // Scan for ncyc cycles from IDLE; model: value k/DWELL positions into the filled list.
  task automatic run_scan(input int ncyc, input bit rand_sel);
    logic [WIDTH-1:0] exp_led;
    int idx;
    scan_en = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      if (rand_sel) begin
        sel = 1'($urandom_range(0, 1));
        D   = WIDTH'($urandom);
      end
      tick();
      idx = (k / DWELL) % count_m;
      exp_led = sel ? D : bank_m[idx];
      checks++;
      if (led !== exp_led || slot !== 2'(idx)) begin
        failures++;
        $display("FAIL scan_step k=%0d: led=%h slot=%0d required led=%h slot=%0d", k, led, slot, exp_led, idx);
      end
    end
    sel = 1'b0;
    scan_en = 1'b0;
    tick();
    checks++;
    if (led !== bank_m[count_m-1] || slot !== 2'(count_m-1)) begin
      failures++;
      $display("FAIL scan_exit: led=%h slot=%0d required led=%h slot=%0d", led, slot, bank_m[count_m-1], count_m-1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cap_btn = 1'b0; scan_en = 1'b0; sel = 1'b0; D = 8'hFF;
    tick(); tick();
    checks++;
    if (led !== 8'h00 || count !== 3'd0 || full !== 1'b0 || overflow !== 1'b0 || slot !== 2'd0) begin
      failures++;
      $display("FAIL reset: led=%h count=%0d full=%0b ovf=%0b slot=%0d required 00/0/0/0/0", led, count, full, overflow, slot);
    end
    rst = 1'b0;
    count_m = 0;
    for (int i = 0; i < DEPTH; i++) bank_m[i] = '0;
  endtask

  task automatic test_single_capture();
    do_reset();
    D = 8'hA5; sel = 1'b0; cap_btn = 1'b1;
    for (int e = 1; e <= DEB + 4; e++) begin
      tick();
      checks++;
      if (count !== ((e >= DEB + 4) ? 3'd1 : 3'd0)) begin
        failures++;
        $display("FAIL latency edge %0d: count=%0d required %0d", e, count, (e >= DEB + 4) ? 1 : 0);
      end
    end
    checks++;
    if (led !== 8'hA5) begin
      failures++;
      $display("FAIL stored_view: led=%h required a5", led);
    end
    sel = 1'b1; D = 8'h3C; #1;
    checks++;
    if (led !== 8'h3C) begin
      failures++;
      $display("FAIL live_view: led=%h required 3c", led);
    end
    sel = 1'b0; cap_btn = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    bank_m[0] = 8'hA5; count_m = 1;
  endtask

  task automatic test_bounce();
    int len;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cap_btn = ((c / 2) % 2) == 0;
      tick();
      checks++;
      if (count !== 3'd0) begin
        failures++;
        $display("FAIL bounce c=%0d: count=%0d required 0", c, count);
      end
    end
    for (int r = 0; r < 8; r++) begin
      cap_btn = ~cap_btn;
      len = $urandom_range(1, DEB - 1);
      for (int i = 0; i < len; i++) tick();
    end
    cap_btn = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (count !== 3'd0) begin
      failures++;
      $display("FAIL bounce_random: count=%0d required 0", count);
    end
    do_press(WIDTH'($urandom));
  endtask

  task automatic test_fill_overflow();
    do_reset();
    do_press(8'h11); do_press(8'h22); do_press(8'h33); do_press(8'h44);
    do_press(8'h55);
    scan_en = 1'b1;
    tick();
    checks++;
    if (led !== 8'h11) begin
      failures++;
      $display("FAIL bank0_after_overflow: led=%h required 11", led);
    end
    scan_en = 1'b0;
    tick();
  endtask

  task automatic test_scan();
    do_reset();
    do_press(8'h11); do_press(8'h22); do_press(8'h33);
    run_scan(4 * DWELL, 1'b0);
  endtask

  task automatic test_random_scan();
    int n;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      n = $urandom_range(1, DEPTH);
      for (int j = 0; j < n; j++) do_press(WIDTH'($urandom));
      run_scan(2 * n * DWELL + $urandom_range(0, 2 * DWELL), 1'b1);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [WIDTH-1:0] v1, v2;
    bit seen1 = 0, seen2 = 0;
    do_reset();
    do_press(WIDTH'($urandom)); do_press(WIDTH'($urandom));
    scan_en = 1'b1;
    for (int i = 0; i < $urandom_range(3, 20); i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (count !== 3'd0 || slot !== 2'd0 || led !== 8'h00 || full !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_scan: count=%0d slot=%0d led=%h full=%0b required 0/0/00/0", count, slot, led, full);
    end
    rst = 1'b0;
    count_m = 0;
    for (int i = 0; i < DEPTH; i++) bank_m[i] = '0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (count !== 3'd0 || slot !== 2'd0) begin
      failures++;
      $display("FAIL idle_after_reset: count=%0d slot=%0d required 0/0", count, slot);
    end
    v1 = WIDTH'($urandom);
    v2 = v1 ^ 8'h5A;
    do_press(v1);
    do_press(v2);
    for (int i = 0; i < 2 * DWELL + 2; i++) begin
      tick();
      if (led === v1) seen1 = 1;
      if (led === v2) seen2 = 1;
    end
    checks++;
    if (!(seen1 && seen2)) begin
      failures++;
      $display("FAIL rescan_after_capture: seen v1=%0b v2=%0b required both", seen1, seen2);
    end
    scan_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_bounce();
    test_fill_overflow();
    test_scan();
    test_random_scan();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
